// File: rtl/parity_pkg.sv
// Shared types for the parity frame checker: FSM state encoding and counter width.
// The optional error counter is enabled by defining PARITY_ERR_CNT_EN.
package parity_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CHECK = 2'd2
    } state_t;

endpackage

// File: rtl/nib_par.sv
// Nibble parity: the same 4-input XOR the downstream stage drives onto outg.
module nib_par (
    input  logic ina,
    input  logic inb,
    input  logic inc,
    input  logic ind,
    output logic outg
);

    assign outg = ina ^ inb ^ inc ^ ind;

endmodule

// File: rtl/parity_frame_chk.sv
// Accumulates nibble parity over FRAME_LEN nibbles and checks it against par_in.
// Define PARITY_ERR_CNT_EN to add the saturating err_cnt output.
module parity_frame_chk
    import parity_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter bit ODD       = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ina,
    input  logic             inb,
    input  logic             inc,
    input  logic             ind,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             par_in,
    output logic             par_out,
    output logic             frame_done,
    output logic             par_err,
    output logic [CNT_W-1:0] frame_cnt
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN + 1) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

    state_t           state, nxt;
    logic             acc;
    logic [IDX_W-1:0] idx;
    logic             exp_q;
    logic             rdy_q;
    logic             nib;
    logic             xfer;
    logic             is_last;

    nib_par u_nib_par (
        .ina  (ina),
        .inb  (inb),
        .inc  (inc),
        .ind  (ind),
        .outg (nib)
    );

    assign xfer    = in_valid && in_ready;
    // In IDLE the incoming nibble is the first one, so it is last only for 1-nibble frames.
    assign is_last = (state == IDLE) ? (FRAME_LEN == 1) : (idx == LAST);
    assign par_out = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE, ACCUM: if (xfer) nxt = is_last ? CHECK : ACCUM;
            CHECK:       nxt = IDLE;
            default:     nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = rdy_q && (state != CHECK);
        frame_done = (state == CHECK);
        par_err    = (state == CHECK) && (acc ^ ODD ^ exp_q);
    end

    // Keeps in_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= 1'b0;
            idx       <= '0;
            exp_q     <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (xfer) begin
                acc <= (state == IDLE) ? nib : (acc ^ nib);
                idx <= (state == IDLE) ? IDX_W'(1) : idx + IDX_W'(1);
                if (is_last) exp_q <= par_in;
            end
            if (state == CHECK) frame_cnt <= frame_cnt + 1'b1;
        end
    end

`ifdef PARITY_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           err_cnt <= '0;
        else if (par_err && (err_cnt != '1))  err_cnt <= err_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_parity_frame_chk.sv
// Bench for parity_frame_chk: an 8-nibble even-parity instance and a 1-nibble odd-parity instance.
module tb_parity_frame_chk;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] d8 = '0, d1 = '0;
    logic       v8 = 1'b0, p8 = 1'b0, v1 = 1'b0, p1 = 1'b0;
    logic       rdy8, po8, fd8, pe8, rdy1, po1, fd1, pe1;
    logic [7:0] fc8, fc1;
`ifdef PARITY_ERR_CNT_EN
    logic [7:0] ec8, ec1;
`endif

    int vecs = 0, miss = 0;
    int done8 = 0, err8 = 0;

    always #5 clk = ~clk;

    parity_frame_chk #(.FRAME_LEN(8), .ODD(1'b0)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .ina(d8[0]), .inb(d8[1]), .inc(d8[2]), .ind(d8[3]),
        .in_valid(v8), .in_ready(rdy8), .par_in(p8), .par_out(po8),
        .frame_done(fd8), .par_err(pe8), .frame_cnt(fc8)
`ifdef PARITY_ERR_CNT_EN
        , .err_cnt(ec8)
`endif
    );

    parity_frame_chk #(.FRAME_LEN(1), .ODD(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .ina(d1[0]), .inb(d1[1]), .inc(d1[2]), .ind(d1[3]),
        .in_valid(v1), .in_ready(rdy1), .par_in(p1), .par_out(po1),
        .frame_done(fd1), .par_err(pe1), .frame_cnt(fc1)
`ifdef PARITY_ERR_CNT_EN
        , .err_cnt(ec1)
`endif
    );

    // Frame-level model: nibbles seen, ones counted, checked-frame and error tallies.
    typedef struct {
        int n;
        int ones;
        bit expq;
        bit chk;
        int frames;
        int errs;
        bit started;
    } mdl_t;

    mdl_t m8, m1;

    function automatic logic [11:0] expect_o(mdl_t m, bit odd);
        bit par;
        par = m.ones[0];
        return {m.started && !m.chk, m.chk, m.chk && (par ^ odd ^ m.expq), par, 8'(m.frames % 256)};
    endfunction

    task automatic advance(inout mdl_t m, input int len, input bit odd,
                           input bit v, input logic [3:0] d, input bit p);
        if (m.chk) begin
            m.frames++;
            if ((m.ones[0] ^ odd ^ m.expq) && m.errs < 255) m.errs++;
            m.chk = 1'b0;
        end else if (v && m.started) begin
            if (m.n == 0) m.ones = $countones(d);
            else          m.ones += $countones(d);
            m.n++;
            if (m.n == len) begin
                m.expq = p;
                m.chk  = 1'b1;
                m.n    = 0;
            end
        end
        m.started = 1'b1;
    endtask

    task automatic cmp(input string nm, input logic [11:0] act, input logic [11:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            m8 = '{default: 0};
            m1 = '{default: 0};
        end
        cmp("dut8_outputs", {rdy8, fd8, pe8, po8, fc8}, expect_o(m8, 1'b0));
        cmp("dut1_outputs", {rdy1, fd1, pe1, po1, fc1}, expect_o(m1, 1'b1));
`ifdef PARITY_ERR_CNT_EN
        cmp("dut8_err_cnt", {4'b0, ec8}, {4'b0, 8'(m8.errs)});
        cmp("dut1_err_cnt", {4'b0, ec1}, {4'b0, 8'(m1.errs)});
`endif
        if (fd8) begin
            done8++;
            if (pe8) err8++;
        end
        if (rst_n) begin
            advance(m8, 8, 1'b0, v8, d8, p8);
            advance(m1, 1, 1'b1, v1, d1, p1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [3:0] d, input bit p);
        int k = 0;
        v8 = 1'b1; d8 = d; p8 = p;
        while (!rdy8 && k < 4) begin tick(); k++; end
        if (!rdy8) lit("send8_ready_timeout", 0, 1);
        tick();
        v8 = 1'b0;
    endtask

    task automatic send1(input logic [3:0] d, input bit p);
        int k = 0;
        v1 = 1'b1; d1 = d; p1 = p;
        while (!rdy1 && k < 4) begin tick(); k++; end
        if (!rdy1) lit("send1_ready_timeout", 0, 1);
        tick();
        v1 = 1'b0;
    endtask

    initial begin
        int d0, e0;
        repeat (3) tick();
        lit("rst_ready", rdy8, 0);
        lit("rst_cnt", fc8, 0);
        lit("rst_pout", po8, 0);
        rst_n = 1'b1;
        #1 lit("ready_before_clk", rdy8, 0);
        tick();
        lit("ready_after_clk", rdy8, 1);

        // All nibbles parity 1, eight of them: acc 0, matches par_in 0.
        for (int i = 0; i < 8; i++) send8(4'b0001, 1'b0);
        lit("A_done_latency", fd8, 1);
        lit("A_err", pe8, 0);
        lit("A_pout", po8, 0);
        tick();
        lit("A_pulse_once", fd8, 0);
        lit("A_cnt", fc8, 1);
        lit("A_ready_back", rdy8, 1);

        // One nibble of parity 0 leaves acc at 1 -> mismatch with par_in 0.
        for (int i = 0; i < 8; i++) send8((i == 3) ? 4'b0011 : 4'b0001, 1'b0);
        lit("B_err", pe8, 1);
        lit("B_pout", po8, 1);
        tick();
        lit("B_cnt", fc8, 2);
        lit("B_pout_hold", po8, 1);
`ifdef PARITY_ERR_CNT_EN
        lit("B_err_cnt", ec8, 1);
`endif

        // 0111 has odd parity like 0001, so acc stays 0.
        for (int i = 0; i < 8; i++) send8((i == 5) ? 4'b0111 : 4'b0001, 1'b0);
        lit("C_err", pe8, 0);
        lit("C_pout", po8, 0);
        tick();

        // Back-to-back stream: the nibble offered during CHECK must be dropped.
        d0 = done8; e0 = err8;
        v8 = 1'b1; p8 = 1'b0;
        for (int i = 0; i < 18; i++) begin
            d8 = (i == 8 || i == 17) ? 4'b0011 : 4'b0001;
            tick();
        end
        v8 = 1'b0;
        lit("S_frames", fc8, 5);
        lit("S_done", done8 - d0, 2);
        lit("S_err", err8 - e0, 0);
        tick();

        // Reset mid-frame discards the partial frame.
        d0 = done8;
        for (int i = 0; i < 5; i++) send8(4'b0001, 1'b0);
        rst_n = 1'b0;
        #1;
        lit("R_cnt_cleared", fc8, 0);
        lit("R_pout_cleared", po8, 0);
        tick();
        rst_n = 1'b1;
        tick();
        lit("R_no_done", done8 - d0, 0);
        for (int i = 0; i < 8; i++) send8((i == 7) ? 4'b0000 : 4'b0001, 1'b1);
        lit("R_done", fd8, 1);
        lit("R_err", pe8, 0);
        lit("R_pout", po8, 1);
        tick();
        lit("R_cnt", fc8, 1);

        // Single-nibble odd-parity frames.
        send1(4'b0000, 1'b1);
        lit("L1_done", fd1, 1);
        lit("L1_err_ok", pe1, 0);
        send1(4'b0000, 1'b0);
        lit("L1_err_bad", pe1, 1);
        send1(4'b1011, 1'b0);
        lit("L1_err_ok2", pe1, 0);
        for (int i = 0; i < 252; i++) send1(4'(i), i[4]);
        tick();
        lit("L1_cnt_255", fc1, 255);
        send1(4'b0000, 1'b1);
        tick();
        lit("L1_cnt_wrap", fc1, 0);

`ifdef PARITY_ERR_CNT_EN
        for (int i = 0; i < 300; i++) send1(4'b0000, 1'b0);
        tick();
        lit("L1_err_cnt_sat", ec1, 255);
`endif

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
